if_id_stage_reg: RTL and testbench
==================================

// Module: if_id_stage_reg
// PURPOSE
//  IF/ID pipeline register of the 5-stage MIPS core; sits between fetch and decode, directly
//  downstream of the hazard detection unit's IF/ID stall output. Holds fetched PC+4/instruction,
//  honours load-use stalls, converts branch/jump flushes into NOP bubbles, tracks slot validity,
//  and keeps saturating stall/flush statistics plus a stuck-stall watchdog.
// PARAMETERS
//  CNT_W      16  width of stall/flush statistic counters (saturating)
//  STALL_MAX  8   max consecutive stall cycles before watchdog error (>=1)
//  NOP_INSTR  32'h0000_0000  instruction word driven for a bubble
// PORTS
//  clk_i          in   1      core clock; all state updates on rising edge
//  rst_i          in   1      synchronous, active-high reset
//  stall_i        in   1      hold request from hazard detection unit (1 = hold IF/ID)
//  flush_i        in   1      branch/jump taken in ID; discard fetched instruction
//  pc_i           in   32     PC+4 of fetched instruction
//  instr_i        in   32     fetched instruction word
//  pc_o           out  32     registered PC+4 to ID
//  instr_o        out  32     registered instruction to ID (NOP_INSTR when bubble)
//  valid_o        out  1      1 = instr_o is a real instruction
//  stall_cnt_o    out  CNT_W  total cycles held by stall
//  flush_cnt_o    out  CNT_W  total flush events accepted
//  wdog_err_o     out  1      sticky: stall_i held > STALL_MAX consecutive cycles
// BEHAVIOUR
//  - Reset (rst_i=1 at edge): pc_o=0, instr_o=NOP_INSTR, valid_o=0, counters=0, run-length=0,
//    wdog_err_o=0, state=EMPTY. Reset mid-stall/flush overrides everything.
//  - Priority per edge: rst_i > flush_i > stall_i > load.
//  - FSM (state encodes slot content): EMPTY (bubble), FULL (valid instr), HOLD (valid, stalled).
//    EMPTY: flush->EMPTY; stall->EMPTY (bubble held); else load->FULL.
//    FULL : flush->EMPTY; stall->HOLD; else load->FULL.
//    HOLD : flush->EMPTY; stall->HOLD; else load->FULL.
//  - load: pc_o<=pc_i, instr_o<=instr_i, valid_o<=1. Latency 1 cycle fetch->ID.
//  - flush: instr_o<=NOP_INSTR, valid_o<=0, pc_o<=pc_i (kept for debug); flush wins over
//    simultaneous stall (bubble inserted, stall cycle not counted).
//  - stall (no flush): pc_o, instr_o, valid_o unchanged; state as above.
//  - stall_cnt_o += 1 each edge with stall_i=1 & flush_i=0; flush_cnt_o += 1 each edge with
//    flush_i=1. Both saturate at 2^CNT_W-1, never wrap.
//  - Run-length counter: +1 per counted stall edge, cleared on any non-stall edge or flush;
//    saturates at STALL_MAX+1. wdog_err_o sets on the edge where run-length would exceed
//    STALL_MAX; cleared only by rst_i. Does not alter datapath behaviour.
//  - All outputs registered; no combinational path input->output.
// TESTING
//  1 rst_i=1 two cycles, release, instr_i=32'h8C22_0004, pc_i=4 -> next cycle valid_o=1,
//    instr_o=8C22_0004, pc_o=4; during reset instr_o=0, valid_o=0.
//  2 Load then stall_i=1 for 1 cycle while instr_i changes to 32'h0043_0820 -> outputs hold
//    8C22_0004 one extra cycle, stall_cnt_o=1, then load 0043_0820.
//  3 flush_i=1 with stall_i=1 same cycle -> instr_o=0, valid_o=0, flush_cnt_o=1, stall_cnt_o
//    unchanged, state EMPTY.
//  4 stall_i=1 for STALL_MAX=8 cycles -> wdog_err_o=0; 9th consecutive -> wdog_err_o=1,
//    stays 1 after stall drops, cleared only by rst_i.
//  5 CNT_W=4: 20 stall cycles -> stall_cnt_o=15 (saturated, no wrap).
//  6 rst_i asserted during HOLD with stall_i=1 -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/if_id_stage_reg.sv
// if_id_stage_reg: IF/ID pipeline register with stall hold, flush bubbles, statistics and stall watchdog
module if_id_stage_reg #(
  parameter int          CNT_W     = 16,
  parameter int          STALL_MAX = 8,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      instr_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      instr_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             wdog_err_o
);
  localparam int RL_W = $clog2(STALL_MAX + 2);
  typedef enum logic [1:0] {EMPTY, FULL, HOLD} state_t;
  state_t state, next_state;
  logic [RL_W-1:0] run_len;
  logic stall_edge;
  assign stall_edge = stall_i & ~flush_i;
  assign valid_o = (state != EMPTY);
  // slot state register; valid_o is a decode of this registered state
  always_ff @(posedge clk_i)
    state <= rst_i ? EMPTY : next_state;
  // flush bubbles the slot, stall keeps whatever is held, otherwise load
  always_comb begin
    next_state = FULL;
    next_state = flush_i ? EMPTY : stall_i ? ((state == EMPTY) ? EMPTY : HOLD) : FULL;
  end
  // datapath, saturating statistics and the consecutive-stall watchdog
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_o        <= '0;
      instr_o     <= NOP_INSTR;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
      run_len     <= '0;
      wdog_err_o  <= 1'b0;
    end else begin
      if (flush_i) begin
        pc_o    <= pc_i;
        instr_o <= NOP_INSTR;
      end else if (!stall_i) begin
        pc_o    <= pc_i;
        instr_o <= instr_i;
      end
      if (stall_edge && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if (flush_i && flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      run_len <= !stall_edge ? '0 : (run_len > RL_W'(STALL_MAX)) ? run_len : run_len + RL_W'(1);
      if (stall_edge && run_len >= RL_W'(STALL_MAX)) wdog_err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_if_id_stage_reg.sv
// tb_if_id_stage_reg: directed scoreboard bench for the IF/ID register
module tb_if_id_stage_reg;
  localparam int CNT_W = 4;
  localparam int STALL_MAX = 8;
  logic clk = 0, rst = 0, stall = 0, flush = 0;
  logic [31:0] pc_in = 0, instr_in = 0;
  logic [31:0] pc_o, instr_o;
  logic valid_o, wdog_err_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  typedef struct {
    logic [31:0] pc, instr;
    logic valid, wdog;
    logic [CNT_W-1:0] scnt, fcnt;
  } exp_t;
  exp_t sb[$];
  exp_t m;
  int run = 0;
  int compared = 0, mismatched = 0;
  if_id_stage_reg #(.CNT_W(CNT_W), .STALL_MAX(STALL_MAX), .NOP_INSTR(32'h0)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .pc_i(pc_in), .instr_i(instr_in),
    .pc_o(pc_o), .instr_o(instr_o), .valid_o(valid_o), .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o), .wdog_err_o(wdog_err_o)
  );
  // free-running clock
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic s, input logic f, input logic [31:0] p, input logic [31:0] i, input string tag);
    exp_t e;
    rst = r; stall = s; flush = f; pc_in = p; instr_in = i;
    if (r) begin
      m = '{pc: 0, instr: 0, valid: 0, wdog: 0, scnt: 0, fcnt: 0};
      run = 0;
    end else if (f) begin
      m.pc = p; m.instr = 0; m.valid = 0;
      if (m.fcnt != 4'hF) m.fcnt++;
      run = 0;
    end else if (s) begin
      if (m.scnt != 4'hF) m.scnt++;
      if (run >= STALL_MAX) m.wdog = 1;
      run = (run > STALL_MAX) ? run : run + 1;
    end else begin
      m.pc = p; m.instr = i; m.valid = 1;
      run = 0;
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".pc"}, pc_o, e.pc);
    chk({tag, ".instr"}, instr_o, e.instr);
    chk({tag, ".valid"}, {31'b0, valid_o}, {31'b0, e.valid});
    chk({tag, ".scnt"}, {28'b0, stall_cnt_o}, {28'b0, e.scnt});
    chk({tag, ".fcnt"}, {28'b0, flush_cnt_o}, {28'b0, e.fcnt});
    chk({tag, ".wdog"}, {31'b0, wdog_err_o}, {31'b0, e.wdog});
  endtask
  // directed sequence
  initial begin
    m = '{pc: 0, instr: 0, valid: 0, wdog: 0, scnt: 0, fcnt: 0};
    step(1, 0, 0, 32'd0, 32'h0, "rst0");
    step(1, 0, 0, 32'd0, 32'h0, "rst1");
    step(0, 0, 0, 32'd4, 32'h8C22_0004, "load1");
    step(0, 1, 0, 32'd8, 32'h0043_0820, "stall1");
    step(0, 0, 0, 32'd8, 32'h0043_0820, "load2");
    step(0, 1, 1, 32'd12, 32'h1111_2222, "flush_stall");
    step(0, 1, 0, 32'd16, 32'h3333_4444, "empty_stall");
    step(0, 0, 0, 32'd16, 32'h3333_4444, "load3");
    for (int k = 0; k < 5; k++) step(0, 1, 0, 32'd20, 32'h5, "run_a");
    step(0, 0, 1, 32'd20, 32'h5, "flush_run");
    for (int k = 0; k < 8; k++) step(0, 1, 0, 32'd24, 32'h6, "wd_le_max");
    step(0, 1, 0, 32'd24, 32'h6, "wd_trip");
    step(0, 0, 0, 32'd28, 32'h7, "wd_sticky");
    step(0, 0, 1, 32'd32, 32'h8, "wd_sticky_fl");
    step(1, 0, 0, 32'd0, 32'h0, "rst2");
    for (int k = 0; k < 20; k++) step(0, 1, 0, 32'd36, 32'h9, "scnt_sat");
    for (int k = 0; k < 17; k++) step(0, 0, 1, 32'd40, 32'hA, "fcnt_sat");
    step(1, 0, 0, 32'd0, 32'h0, "rst3");
    step(0, 0, 0, 32'd44, 32'hDEAD_BEEF, "load4");
    step(0, 1, 0, 32'd48, 32'hCAFE_F00D, "hold");
    step(1, 1, 0, 32'd52, 32'h1234_5678, "rst_in_hold");
    step(0, 0, 0, 32'd56, 32'h0BAD_CAFE, "load5");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
